// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, defaults and round-robin pick helper for mem_rr_arbiter
package mem_arb_pkg;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 32;
    localparam int DEPTH_DEF = 256;
    localparam int MAX_NREQ  = 8;
    localparam int ID_W      = $clog2(MAX_NREQ);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
        logic            rd;
        logic            err;
    } rsp_tag_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } pick_t;

    // Scan from the far end back toward ptr so the nearest valid requester wins.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                      input logic [ID_W-1:0]     ptr,
                                      input int                  n);
        pick_t p;
        int    k;
        p = '0;
        for (int i = MAX_NREQ - 1; i >= 0; i--) begin
            if (i < n) begin
                k = int'(ptr) + i;
                if (k >= n) k = k - n;
                if (valid[k]) begin
                    p.found = 1'b1;
                    p.idx   = ID_W'(k);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// rtl/mem_rr_arbiter_if.sv - requester command/response bundle for mem_rr_arbiter
interface mem_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic               rsp_err;
    logic [DW-1:0]      rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - round-robin pointer register and combinational grant select
module rr_grant
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid,
    output logic            grant_vld,
    output logic [ID_W-1:0] grant_idx,
    output logic [NREQ-1:0] ready
);

    logic [ID_W-1:0]     ptr;
    logic [MAX_NREQ-1:0] vpad;
    pick_t               pick;

    always_comb begin
        vpad            = '0;
        vpad[NREQ-1:0]  = valid;
        pick            = rr_pick(vpad, ptr, NREQ);
        grant_vld       = pick.found && !rst;
        grant_idx       = pick.idx;
        ready           = '0;
        if (grant_vld) ready[pick.idx] = 1'b1;
    end

    // A grant always lands on a valid requester, so every grant is a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_vld) begin
            if (pick.idx == ID_W'(NREQ - 1)) ptr <= '0;
            else                             ptr <= pick.idx + ID_W'(1);
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin sharing of one memory unit with tagged read-data return
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_rr_arbiter_if.slave req,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_d_in,
    output logic          mem_rd_req,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_data_out
);

    localparam int LAT = (RD_LAT < 1) ? 1 : RD_LAT;

    logic            gnt_vld;
    logic [ID_W-1:0] gnt_idx;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata;
    logic            g_we;
    logic            in_range;
    rsp_tag_t        pipe [LAT];
    rsp_tag_t        tail;
    logic            tail_live;

    rr_grant #(.NREQ(NREQ)) u_grant (
        .clk       (clk),
        .rst       (rst),
        .valid     (req.req_valid),
        .grant_vld (gnt_vld),
        .grant_idx (gnt_idx),
        .ready     (req.req_ready)
    );

    always_comb begin
        g_addr      = req.req_addr[int'(gnt_idx)*AW +: AW];
        g_wdata     = req.req_wdata[int'(gnt_idx)*DW +: DW];
        g_we        = req.req_we[gnt_idx];
        in_range    = g_addr < AW'(DEPTH);
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_d_in    = '0;
        mem_rd_req  = 1'b0;
        mem_rd_addr = '0;
        if (gnt_vld && in_range) begin
            if (g_we) begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = g_addr;
                mem_d_in    = g_wdata;
            end else begin
                mem_rd_req  = 1'b1;
                mem_rd_addr = g_addr;
            end
        end
    end

    // Every response type rides the same depth so responses stay ordered and one per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= '{vld: gnt_vld, id: gnt_idx, rd: !g_we, err: !in_range};
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    // Reset masks the tail too, so a read caught by reset never produces a strobe.
    always_comb begin
        tail          = pipe[LAT-1];
        tail_live     = tail.vld && !rst;
        req.rsp_valid = '0;
        if (tail_live) req.rsp_valid[tail.id] = 1'b1;
        req.rsp_err   = tail_live && tail.err;
        req.rsp_rdata = (tail_live && tail.rd && !tail.err) ? mem_data_out : '0;
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - table-driven scoreboard bench for mem_rr_arbiter
module tb_mem_rr_arbiter;

    logic        clk;
    logic        rst;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_d_in;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_data_out;

    mem_rr_arbiter_if #(.NREQ(4), .DW(32), .AW(32)) bus ();

    mem_rr_arbiter #(.NREQ(4), .DW(32), .AW(32), .DEPTH(256), .RD_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (bus),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_d_in     (mem_d_in),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (mem_wr_en)  ram[mem_wr_addr[7:0]] <= mem_d_in;
        if (mem_rd_req) mem_data_out <= ram[mem_rd_addr[7:0]];
    end

    typedef struct {
        logic [3:0]       v;
        logic [3:0]       we;
        logic [3:0][31:0] a;
        logic [3:0][31:0] d;
        logic [3:0]       rdy;
    } vec_t;

    typedef struct {
        logic [3:0]  v;
        logic        err;
        logic [31:0] data;
    } exp_rsp_t;

    exp_rsp_t    sbq [$];
    logic [31:0] shadow [256];
    int          mptr;
    int          total;
    int          bad;
    vec_t        tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] v, input logic [3:0] we,
                        input logic [3:0][31:0] a, input logic [3:0][31:0] d,
                        input logic [3:0] rdy);
        int          g;
        int          k;
        logic [3:0]  erdy;
        logic        ewr, erd;
        logic [31:0] ewa, ewd, era;
        exp_rsp_t    e;
        rst           = r;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        g = -1;
        for (int i = 0; i < 4; i++) begin
            k = (mptr + i) % 4;
            if (g < 0 && v[k]) g = k;
        end
        if (r) g = -1;
        erdy = (g < 0) ? 4'b0 : 4'(1 << g);
        chk("ready", 64'(bus.req_ready), 64'(erdy));
        chk("ready_tbl", 64'(bus.req_ready), 64'(rdy));
        ewr = 0; erd = 0; ewa = 0; ewd = 0; era = 0;
        if (g >= 0 && a[g] < 256) begin
            if (we[g]) begin ewr = 1; ewa = a[g]; ewd = d[g]; end
            else       begin erd = 1; era = a[g]; end
        end
        chk("mem_wr_en", 64'(mem_wr_en), 64'(ewr));
        chk("mem_wr_addr", 64'(mem_wr_addr), 64'(ewa));
        chk("mem_d_in", 64'(mem_d_in), 64'(ewd));
        chk("mem_rd_req", 64'(mem_rd_req), 64'(erd));
        chk("mem_rd_addr", 64'(mem_rd_addr), 64'(era));
        e = '{v: 4'b0, err: 1'b0, data: 32'h0};
        if (sbq.size() > 0) e = sbq.pop_front();
        if (r) e = '{v: 4'b0, err: 1'b0, data: 32'h0};
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(e.v));
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.data));
        @(posedge clk);
        if (r) begin
            mptr = 0;
            sbq.delete();
        end else if (g >= 0) begin
            if (a[g] >= 256)
                sbq.push_back('{v: 4'(1 << g), err: 1'b1, data: 32'h0});
            else if (we[g]) begin
                sbq.push_back('{v: 4'(1 << g), err: 1'b0, data: 32'h0});
                shadow[a[g][7:0]] = d[g];
            end else
                sbq.push_back('{v: 4'(1 << g), err: 1'b0, data: shadow[a[g][7:0]]});
            mptr = (g + 1) % 4;
        end
        #1;
    endtask

    localparam logic [3:0][31:0] A4 = {32'h57, 32'h56, 32'h55, 32'h54};
    localparam logic [3:0][31:0] D4 = {32'hDDDD5678, 32'hCCCC5678, 32'hBBBB5678, 32'hAAAA5678};
    localparam logic [3:0][31:0] Z4 = '0;

    initial begin
        total = 0;
        bad   = 0;
        mptr  = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 32'h0;
            shadow[i] = 32'h0;
        end
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        tbl[0]  = '{4'b1111, 4'b1111, A4, D4, 4'b0001};
        tbl[1]  = '{4'b1110, 4'b1111, A4, D4, 4'b0010};
        tbl[2]  = '{4'b1100, 4'b1111, A4, D4, 4'b0100};
        tbl[3]  = '{4'b1000, 4'b1111, A4, D4, 4'b1000};
        tbl[4]  = '{4'b1000, 4'b0000, {32'h54, 32'h0, 32'h0, 32'h0}, Z4, 4'b1000};
        tbl[5]  = '{4'b1000, 4'b0000, {32'h55, 32'h0, 32'h0, 32'h0}, Z4, 4'b1000};
        tbl[6]  = '{4'b1000, 4'b0000, {32'h56, 32'h0, 32'h0, 32'h0}, Z4, 4'b1000};
        tbl[7]  = '{4'b1000, 4'b0000, {32'h57, 32'h0, 32'h0, 32'h0}, Z4, 4'b1000};
        tbl[8]  = '{4'b1010, 4'b0000, A4, Z4, 4'b0010};
        tbl[9]  = '{4'b1010, 4'b0000, A4, Z4, 4'b1000};
        tbl[10] = '{4'b1010, 4'b0000, A4, Z4, 4'b0010};
        tbl[11] = '{4'b1010, 4'b0000, A4, Z4, 4'b1000};
        tbl[12] = '{4'b0000, 4'b0000, Z4, Z4, 4'b0000};

        #1;
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 4'b1111, A4, D4, 4'b0000);

        for (int i = 0; i < 13; i++)
            step(1'b0, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rdy);

        step(1'b0, 4'b0001, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h54},
             {32'h0, 32'h0, 32'h0, 32'hAAAA5678}, 4'b0001);
        step(1'b0, 4'b0001, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h54}, Z4, 4'b0001);
        step(1'b0, 4'b0000, 4'b0000, Z4, Z4, 4'b0000);

        step(1'b0, 4'b0100, 4'b0000, {32'h0, 32'h100, 32'h0, 32'h0}, Z4, 4'b0100);
        step(1'b0, 4'b0100, 4'b0100, {32'h0, 32'h1FF, 32'h0, 32'h0},
             {32'h0, 32'h12345678, 32'h0, 32'h0}, 4'b0100);
        step(1'b0, 4'b0000, 4'b0000, Z4, Z4, 4'b0000);

        step(1'b0, 4'b0010, 4'b0000, {32'h0, 32'h0, 32'h55, 32'h0}, Z4, 4'b0010);
        step(1'b1, 4'b0000, 4'b0000, Z4, Z4, 4'b0000);
        step(1'b1, 4'b0000, 4'b0000, Z4, Z4, 4'b0000);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 4'b0000, Z4, Z4, 4'b0000);
        step(1'b0, 4'b0001, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h55}, Z4, 4'b0001);
        step(1'b0, 4'b0000, 4'b0000, Z4, Z4, 4'b0000);
        chk("read_0x55_shadow", 64'(shadow[8'h55]), 64'h0000_0000_BBBB_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
